// File: rtl/tinker_pkg.sv
// Tinker prefetch shared types and constants.
// Imported by the prefetch top and its FIFO.
package tinker_pkg;

  localparam logic [63:0] TINKER_RESET_PC = 64'h2000;
  localparam int TINKER_INST_W = 32;
  localparam int TINKER_ADDR_W = 64;

  typedef enum logic {
    PF_RUN,
    PF_HALTED
  } pf_state_t;

  typedef struct packed {
    logic [TINKER_ADDR_W-1:0] pc;
    logic [TINKER_INST_W-1:0] word;
  } pf_entry_t;

endpackage

// File: rtl/tinker_inst_fifo.sv
// In-order instruction queue of {pc, word} entries.
// Flush empties it; pointers wrap naturally (DEPTH is a power of two).
module tinker_inst_fifo
  import tinker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  pf_entry_t              push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] occ,
  output pf_entry_t              head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pf_entry_t        mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (occ != '0);
  assign do_push = push &
                   ((occ != CW'(DEPTH)) | do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy update; storage needs no reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      occ <= occ + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/tinker_prefetch.sv
// Tinker instruction prefetch: sequential fetch, in-order queue,
// stale-response dropping on redirect, freeze on halt.
module tinker_prefetch
  import tinker_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = TINKER_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_word,
  output logic [63:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        hlt
);

  localparam int CW = $clog2(DEPTH) + 1;

  pf_state_t   state;
  logic [63:0] fetch_pc;
  logic [63:0] resp_pc;
  logic [63:0] new_pc;
  logic [CW-1:0] occ;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] out_next;
  logic [CW:0]   inflight;
  logic        run;
  logic        issue;
  logic        rv;
  logic        redir;
  logic        push;
  logic        pop;
  logic        has_head;
  pf_entry_t   head;
  pf_entry_t   push_data;

  assign run      = (state == PF_RUN);
  assign inflight = {1'b0, occ} + {1'b0, outstanding};
  assign imem_req = reset & run &
                    (inflight < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign issue    = imem_req & imem_gnt;
  // A response with nothing outstanding is ignored.
  assign rv       = imem_rvalid & (outstanding != '0);
  assign out_next = outstanding + CW'(issue) - CW'(rv);
  assign redir    = run & ~hlt & redirect_valid;
  assign push     = run & ~hlt & ~redir & rv &
                    (drop_cnt == '0);
  assign has_head = (occ != '0);
  assign inst_valid = run & has_head;
  assign pop      = inst_valid & inst_ready &
                    ~hlt & ~redir;
  assign new_pc   = redirect_pc & ~64'd3;
  assign push_data = '{pc: resp_pc, word: imem_rdata};
  assign inst_word = has_head ? head.word : '0;
  assign inst_pc   = has_head ? head.pc : '0;

  tinker_inst_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (redir),
    .occ      (occ),
    .head     (head)
  );

  // Run/halt state, fetch and response PCs, in-flight counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= PF_RUN;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_next;
      if (rv && drop_cnt != '0) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (issue) begin
        fetch_pc <= fetch_pc + 64'd4;
      end
      if (push) begin
        resp_pc <= resp_pc + 64'd4;
      end
      unique case (state)
        PF_RUN: begin
          if (hlt) begin
            state <= PF_HALTED;
          end else if (redirect_valid) begin
            fetch_pc <= new_pc;
            resp_pc  <= new_pc;
            drop_cnt <= out_next;
          end
        end
        PF_HALTED: begin
          state <= PF_HALTED;
        end
      endcase
    end
  end

  a_rvalid_outstanding: assert property (
    @(posedge clk) disable iff (!reset)
    imem_rvalid |-> (outstanding != '0)
  );

endmodule

// File: tb/tb_tinker_prefetch.sv
// Scoreboard bench for tinker_prefetch with a
// variable-latency in-order memory model.
module tb_tinker_prefetch;
  import tinker_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst_word;
  logic [63:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        hlt = 1'b0;

  typedef struct {
    logic [63:0] addr;
    int          due;
    int          ep;
  } req_t;

  req_t        mq[$];
  pf_entry_t   sb[$];
  int          errors = 0;
  int          checks = 0;
  int          n = 0;
  int          lat = 1;
  int          rst_cyc = 0;
  int          ep = 0;
  logic        m_halted = 1'b0;
  logic [63:0] exp_fetch = TINKER_RESET_PC;
  logic [63:0] exp_rpc = TINKER_RESET_PC;

  always #5 clk = ~clk;

  tinker_prefetch #(
    .DEPTH(DEPTH),
    .RESET_PC(TINKER_RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_word     (inst_word),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .hlt           (hlt)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(
    input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
  endfunction

  // Model, memory responder and scoreboard, all at negedge.
  always @(negedge clk) begin
    pf_entry_t e;
    req_t      r;
    logic      redir_now;
    logic      halt_now;
    logic      exp_req;
    if (!reset) begin
      if (rst_cyc > 0) begin
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, TINKER_RESET_PC);
        check("rst_valid", inst_valid, 0);
        check("rst_word", inst_word, 0);
        check("rst_pc", inst_pc, 0);
      end
      rst_cyc++;
      mq.delete();
      sb.delete();
      m_halted = 1'b0;
      exp_fetch = TINKER_RESET_PC;
      exp_rpc = TINKER_RESET_PC;
      imem_rvalid = 1'b0;
      ep++;
    end else begin
      rst_cyc = 0;
      halt_now = hlt && !m_halted;
      redir_now = redirect_valid && !hlt && !m_halted;
      exp_req = !m_halted &&
                (sb.size() + mq.size() < DEPTH);
      check("req", imem_req, exp_req);
      check("valid", inst_valid,
            !m_halted && sb.size() != 0);
      if (imem_req)
        check("addr", imem_addr, exp_fetch);
      if (inst_valid && inst_ready &&
          !redir_now && !halt_now) begin
        if (sb.size() == 0) begin
          check("pop_empty", inst_valid, 0);
        end else begin
          e = sb.pop_front();
          check("pc", inst_pc, e.pc);
          check("word", inst_word, e.word);
        end
      end
      if (mq.size() != 0 && mq[0].due <= n) begin
        r = mq.pop_front();
        imem_rvalid = 1'b1;
        imem_rdata = mem_word(r.addr);
        if (!m_halted && !halt_now && !redir_now &&
            r.ep == ep) begin
          sb.push_back('{pc: exp_rpc,
                         word: imem_rdata});
          exp_rpc += 64'd4;
        end
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata = $urandom;
      end
      if (imem_req && imem_gnt) begin
        mq.push_back('{addr: imem_addr,
                       due: n + lat, ep: ep});
        exp_fetch += 64'd4;
      end
      if (redir_now) begin
        ep++;
        exp_fetch = redirect_pc & ~64'd3;
        exp_rpc = exp_fetch;
        sb.delete();
      end
      if (halt_now) m_halted = 1'b1;
    end
    n++;
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  // Directed phases followed by a short random phase.
  initial begin
    imem_gnt = 1'b1;
    inst_ready = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(12);
    inst_ready = 1'b0;
    tick(10);
    inst_ready = 1'b1;
    tick(8);
    lat = 3;
    tick(6);
    redirect(64'h3002);
    tick(12);
    lat = 1;
    tick(6);
    redirect(64'h4000);
    tick(8);
    repeat (60) begin
      imem_gnt = 1'($urandom_range(0, 1));
      inst_ready = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = {$urandom, $urandom};
      lat = $urandom_range(1, 3);
      tick(1);
    end
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    inst_ready = 1'b1;
    lat = 1;
    tick(8);
    inst_ready = 1'b0;
    tick(4);
    hlt = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h5000;
    tick(1);
    hlt = 1'b0;
    redirect_valid = 1'b0;
    tick(3);
    redirect(64'h6000);
    inst_ready = 1'b1;
    tick(6);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(8);
    redirect(64'hFFFF_FFFF_FFFF_FFFE);
    tick(8);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/tinker_prefetch.md
# tinker_prefetch

Instruction prefetch stage directly upstream of the Tinker instruction decoder. It issues sequential 32-bit instruction fetches to the instruction memory port and buffers the returned words with their PCs in a small in-order queue. It presents one instruction per handshake to the decoder. It discards stale fetches when a branch, call or return redirects the PC, and stops fetching on halt.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 64'h2000: first fetch address after reset.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low. 0 = reset, sampled on the clk edge.
- imem_req  out  1  fetch request valid.
- imem_addr  out  64  byte address of requested word; bits [1:0] always 0.
- imem_gnt  in  1  request accepted this cycle (imem_req & imem_gnt = issue).
- imem_rvalid  in  1  response valid; responses return in issue order, latency at least 1 cycle.
- imem_rdata  in  32  little-endian instruction word ({byte+3, byte+2, byte+1, byte}).
- inst_valid  out  1  queue head valid toward the decoder.
- inst_word  out  32  head instruction.
- inst_pc  out  64  head PC.
- inst_ready  in  1  decoder consumes head (inst_valid & inst_ready = pop).
- redirect_valid  in  1  PC redirect from the ALU/PC mux.
- redirect_pc  in  64  new fetch PC; bits [1:0] are forced to 0.
- hlt  in  1  halt from the ALU.

## Operation
- State machine, states RUN and HALTED:
  - Reset forces RUN.
  - In RUN, hlt=1 moves the block to HALTED.
  - HALTED is left only by reset.
- Registers:
  - fetch_pc: next address to request.
  - occ: queue occupancy, 0..DEPTH.
  - outstanding: issued but not yet returned, 0..DEPTH.
  - drop_cnt: responses still to discard, 0..DEPTH.
- Issue condition, RUN only: imem_req = (occ + outstanding < DEPTH), computed from registered values. A pop in the same cycle does not unlock an issue until the next cycle.
- imem_addr = fetch_pc.
- On issue: fetch_pc += 4, wrapping modulo 2^64, and outstanding increments.
- On rvalid: outstanding decrements.
  - If drop_cnt > 0, the data is discarded and drop_cnt decrements.
  - Otherwise {PC, word} is pushed. The PC is tracked in a separate response-PC counter that advances by 4 per accepted response.
- Pop: head advances and occ decrements. Push and pop in the same cycle leave occ unchanged.
- Redirect in RUN takes priority over that cycle's push and pop:
  - The queue is flushed (occ=0).
  - fetch_pc and the response-PC counter both become redirect_pc & ~3.
  - drop_cnt becomes the outstanding count after this cycle's issue/return events. All in-flight responses are stale, including a request granted in the redirect cycle, which carries the old address.
  - An rvalid in the redirect cycle is discarded.
- HALTED:
  - imem_req=0 and inst_valid=0.
  - Queue contents are frozen.
  - Responses are still counted down (outstanding, drop_cnt) but never pushed.
  - redirect_valid is ignored.
- hlt and redirect_valid in the same cycle: halt wins and the redirect is ignored.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_word=0, inst_pc=0. Internally occ=0, outstanding=0, drop_cnt=0, state RUN.
- First request: imem_req=1 in the first cycle after reset deasserts, address RESET_PC.
- Response-to-decoder latency: data pushed at rvalid edge N is on inst_* with inst_valid=1 in cycle N+1. There is no bypass.
- Redirect latency: redirect at edge N puts imem_addr=redirect_pc in cycle N+1. The first valid instruction appears one cycle after its response.
- inst_word and inst_pc stay stable while inst_valid=1 and inst_ready=0.
- Full (occ=DEPTH): imem_req=0.
- rvalid with outstanding=0 is a protocol error. It is ignored and covered by an assertion.

## Structure
- Package tinker_pkg holds:
  - TINKER_RESET_PC = 64'h2000
  - TINKER_INST_W = 32 and TINKER_ADDR_W = 64
  - pf_state_t enum {PF_RUN, PF_HALTED}
  - the queue entry struct {pc, word}
- One sub-module, tinker_inst_fifo: synchronous FIFO of DEPTH entries with push, pop, flush, occupancy and head outputs.
- The prefetch top holds the state machine, counters and PC registers.

## Test plan
- Reset, always-grant memory with 1-cycle latency, inst_ready=1 → PCs 0x2000, 0x2004, 0x2008 on inst_pc in consecutive cycles, words matching memory.
- inst_ready=0, DEPTH=4, 1-cycle memory → exactly 4 issues, then imem_req=0. Raising inst_ready pops one per cycle, and imem_req resumes the following cycle.
- 3-cycle memory latency, 2 requests in flight, redirect_pc=0x3002 → both late responses discarded; the next inst_pc is 0x3000, and 0x3004 follows.
- Redirect in the same cycle as rvalid and as a grant → the rvalid word and the granted request's response are both discarded, with no spurious inst_valid.
- hlt=1 with 2 queued entries → inst_valid=0 and imem_req=0 from the next cycle. A later redirect has no effect. reset=0 for one cycle restarts fetching at 0x2000.
- fetch_pc=64'hFFFF_FFFF_FFFF_FFFC → the next issue address is 0 (wrap).
